proc_mem_responder: RTL

Single-port word memory that serves the processor's fetch and load/store accesses, acting as the responder end of the processor memory interface. It accepts one request at a time over a valid/ready request channel, waits a fixed programmable latency, and then returns read data or a write acknowledgement over a valid/ready response channel. A side load port preloads program and data images before the core runs.

---
 rtl/proc_mem_responder.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/proc_mem_responder.sv
// ---------------------------------------------------------------------------
// proc_mem_responder
//
// Responder end of the processor memory interface. A single-port word memory
// accepts one fetch/load/store request at a time, waits a fixed LATENCY, then
// returns read data or a write acknowledgement. A side load port preloads
// program and data images.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset (control and response regs only;
//                memory contents survive reset)
//   req_valid  : request present
//   req_ready  : responder idle and able to accept a request
//   req_we     : 1 = write, 0 = read
//   req_addr   : word address
//   req_wdata  : write data
//   rsp_valid  : response present
//   rsp_ready  : requester accepts the response
//   rsp_rdata  : read data (0 for writes and errors)
//   rsp_err    : request address was outside the implemented DEPTH
//   ld_en      : preload write strobe
//   ld_addr    : preload address (addresses >= DEPTH are ignored)
//   ld_data    : preload data
// ---------------------------------------------------------------------------
module proc_mem_responder #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 16,
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   input  logic              ld_en,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   // LATENCY is at most 15, so four bits hold the countdown.
   localparam int                 CNT_W    = 4;
   localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(LATENCY - 1);
   // One extra bit so DEPTH == 2**ADDR_W is representable.
   localparam logic [ADDR_W:0]    DEPTH_L  = (ADDR_W+1)'(DEPTH);

   state_t              r_state;
   state_t              w_next_state;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W-1:0]   r_rdata;
   logic                r_err;
   logic [DATA_W-1:0]   r_mem [0:DEPTH-1];

   logic                w_accept;
   logic                w_commit;
   logic                w_in_range;
   logic                w_ld_in_range;
   logic                w_core_wr;

   assign w_accept      = (r_state == S_IDLE) && req_valid;
   assign w_commit      = (r_state == S_WAIT) && (r_cnt == '0);
   assign w_in_range    = ({1'b0, r_addr} < DEPTH_L);
   assign w_ld_in_range = ({1'b0, ld_addr} < DEPTH_L);
   // A write whose commit edge coincides with reset is discarded.
   assign w_core_wr     = w_commit && r_we && w_in_range && !rst;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (req_valid)      w_next_state = S_WAIT;
         S_WAIT:  if (r_cnt == '0)    w_next_state = S_RESP;
         S_RESP:  if (rsp_ready)      w_next_state = S_IDLE;
         default:                     w_next_state = S_IDLE;
      endcase
   end

   // Request capture; data only, no reset needed.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_we    <= req_we;
         r_addr  <= req_addr;
         r_wdata <= req_wdata;
      end
   end

   // Latency countdown and response registers. The response is captured on
   // the commit edge and then held untouched through RESP.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt   <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else if (w_accept) begin
         r_cnt <= CNT_LOAD;
      end else if (r_state == S_WAIT) begin
         if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end else begin
            r_err   <= !w_in_range;
            r_rdata <= (!r_we && w_in_range) ? r_mem[r_addr] : '0;
         end
      end
   end

   // Memory array. The core write is issued last so it wins a same-address
   // collision with the preload port.
   always_ff @(posedge clk) begin
      if (ld_en && w_ld_in_range) begin
         r_mem[ld_addr] <= ld_data;
      end
      if (w_core_wr) begin
         r_mem[r_addr] <= r_wdata;
      end
   end

   assign req_ready = (r_state == S_IDLE);
   assign rsp_valid = (r_state == S_RESP);
   assign rsp_rdata = r_rdata;
   assign rsp_err   = r_err;

endmodule
